// File: rtl/mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_pkg : select encoding and arbitration pointer type for the 2:1 mux path |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [0:0] {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

endpackage
`default_nettype wire

// File: rtl/mux_in_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_in_slot : one-entry input buffer with full flag and ready logic        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_in_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_push;

  // A pop in the same cycle frees the entry, so a refill is accepted at once.
  assign ready  = !r_full || pop;
  assign w_push = push_valid && ready;
  assign full   = r_full;
  assign data   = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_push) begin
        r_full <= 1'b1;
        r_data <= push_data;
      end else if (pop) begin
        r_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux2_rr_arbiter : two-channel round-robin arbiter feeding the 2:1 mux path |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux2_rr_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             s0,
  input  logic             y_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_a_full, w_b_full;
  logic [WIDTH-1:0] w_a_word, w_b_word;
  logic             w_out_load;
  logic             w_grant_a, w_grant_b;
  pri_t             r_pri, w_pri_next;

  logic             r_y_valid;
  logic [WIDTH-1:0] r_y_data;
  logic             r_s0;
  logic [CNT_W-1:0] r_a_cnt, r_b_cnt;

  mux_in_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (a_valid),
    .push_data  (a_data),
    .pop        (w_grant_a),
    .ready      (a_ready),
    .full       (w_a_full),
    .data       (w_a_word)
  );

  mux_in_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (b_valid),
    .push_data  (b_data),
    .pop        (w_grant_b),
    .ready      (b_ready),
    .full       (w_b_full),
    .data       (w_b_word)
  );

  // Gating grants with out_load keeps the pointer and output frozen on a stall.
  assign w_out_load = !r_y_valid || y_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pri <= PRI_A;
    end else begin
      r_pri <= w_pri_next;
    end
  end

  always_comb begin
    w_pri_next = r_pri;
    w_grant_a  = w_out_load && w_a_full && (!w_b_full || (r_pri == PRI_A));
    w_grant_b  = w_out_load && w_b_full && (!w_a_full || (r_pri == PRI_B));
    if (w_grant_a) begin
      w_pri_next = PRI_B;
    end else if (w_grant_b) begin
      w_pri_next = PRI_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_s0      <= SEL_A;
      r_a_cnt   <= '0;
      r_b_cnt   <= '0;
    end else if (w_out_load) begin
      if (w_grant_a) begin
        r_y_valid <= 1'b1;
        r_y_data  <= w_a_word;
        r_s0      <= SEL_A;
        r_a_cnt   <= r_a_cnt + c_cnt_one;
      end else if (w_grant_b) begin
        r_y_valid <= 1'b1;
        r_y_data  <= w_b_word;
        r_s0      <= SEL_B;
        r_b_cnt   <= r_b_cnt + c_cnt_one;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;
  assign s0      = r_s0;
  assign a_cnt   = r_a_cnt;
  assign b_cnt   = r_b_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux2_rr_arbiter : directed self-checking bench for mux2_rr_arbiter      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid, b_valid, y_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready, y_valid, s0;
  logic [WIDTH-1:0] y_data;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .s0      (s0),
    .y_ready (y_ready),
    .a_cnt   (a_cnt),
    .b_cnt   (b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    y_ready = 1'b0;
    a_data  = '0;
    b_data  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Push n words on channel A (data incrementing from start); bounded wait.
  task automatic send_a(input int n, input logic [WIDTH-1:0] start);
    int sent = 0;
    int guard = 0;
    logic acc;
    a_valid = 1'b1;
    a_data  = start;
    while (sent < n && guard < 100) begin
      acc = a_valid && a_ready;
      tick();
      guard++;
      if (acc) begin
        sent++;
        a_data = a_data + 8'd1;
        if (sent == n) a_valid = 1'b0;
      end
    end
    a_valid = 1'b0;
    if (sent < n) chk("send_a_timeout", sent, n);
  endtask

  initial begin
    logic acc_a, acc_b;

    rst_n   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    y_ready = 1'b0;
    a_data  = '0;
    b_data  = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data",  y_data,  0);
    chk("rst_s0",      s0,      0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_a_cnt",   a_cnt,   0);
    chk("rst_b_cnt",   b_cnt,   0);
    tick();
    rst_n = 1'b1;

    // Single A word: visible one edge after acceptance.
    y_ready = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'h11;
    tick();
    a_valid = 1'b0;
    chk("lat_not_yet", y_valid, 0);
    tick();
    chk("single_valid", y_valid, 1);
    chk("single_data",  y_data,  8'h11);
    chk("single_s0",    s0,      0);
    chk("single_a_cnt", a_cnt,   1);
    tick();
    chk("single_drain", y_valid, 0);

    // Continuous dual load from a fresh pointer: strict alternation A,B,A,B.
    do_reset();
    y_ready = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 8'h01;
    b_data  = 8'h81;
    for (int k = -1; k < 8; k++) begin
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (acc_a) a_data = a_data + 8'd1;
      if (acc_b) b_data = b_data + 8'd1;
      if (k >= 0) begin
        chk("alt_valid", y_valid, 1);
        chk("alt_data",  y_data,  (k % 2 == 0) ? (8'h01 + k / 2) : (8'h81 + k / 2));
        chk("alt_s0",    s0,      (k % 2 == 0) ? 0 : 1);
      end
    end
    chk("alt_a_cnt", a_cnt, 4);
    chk("alt_b_cnt", b_cnt, 4);

    // Stall with both slots full (A holds 05, B holds 85).
    y_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_data",    y_data,  8'h84);
      chk("stall_s0",      s0,      1);
      chk("stall_a_ready", a_ready, 0);
      chk("stall_b_ready", b_ready, 0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    y_ready = 1'b1;
    tick();
    chk("rel_a_data", y_data, 8'h05);
    chk("rel_a_s0",   s0,     0);
    tick();
    chk("rel_b_data", y_data, 8'h85);
    chk("rel_b_s0",   s0,     1);
    tick();
    chk("rel_drain",  y_valid, 0);

    // Only B for three words, then A and B together: A first.
    b_valid = 1'b1;
    b_data  = 8'h91;
    for (int k = -1; k < 3; k++) begin
      acc_b = b_valid && b_ready;
      tick();
      if (acc_b) begin
        if (b_data == 8'h93) b_valid = 1'b0;
        else b_data = b_data + 8'd1;
      end
      if (k >= 0) begin
        chk("bonly_valid", y_valid, 1);
        chk("bonly_data",  y_data,  8'h91 + k);
        chk("bonly_s0",    s0,      1);
      end
    end
    a_valid = 1'b1;
    a_data  = 8'hA1;
    b_valid = 1'b1;
    b_data  = 8'hB1;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    chk("both_first_data", y_data, 8'hA1);
    chk("both_first_s0",   s0,     0);
    tick();
    chk("both_second_data", y_data, 8'hB1);
    chk("both_second_s0",   s0,     1);
    tick();
    chk("cnt_a_6", a_cnt, 6);
    chk("cnt_b_9", b_cnt, 9);

    // Counter wrap with a 4-bit counter: 6 + 9 = 15, then one more wraps to 0.
    send_a(9, 8'h20);
    tick();
    tick();
    chk("cnt_a_max", a_cnt, 4'hF);
    send_a(1, 8'h30);
    tick();
    tick();
    chk("cnt_a_wrap", a_cnt, 0);
    chk("cnt_wrap_y", y_data, 8'h30);
    chk("cnt_b_hold", b_cnt, 9);

    // Asynchronous reset mid-stream with both slots full and y_valid high.
    y_ready = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'hC1;
    b_valid = 1'b1;
    b_data  = 8'hD1;
    tick();
    a_valid = 1'b0;
    b_data  = 8'hD2;
    tick();
    b_valid = 1'b0;
    chk("pre_rst_valid", y_valid, 1);
    chk("pre_rst_data",  y_data,  8'hD1);
    chk("pre_rst_a_rdy", a_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y_valid", y_valid, 0);
    chk("arst_y_data",  y_data,  0);
    chk("arst_s0",      s0,      0);
    chk("arst_a_ready", a_ready, 1);
    chk("arst_b_ready", b_ready, 1);
    chk("arst_a_cnt",   a_cnt,   0);
    chk("arst_b_cnt",   b_cnt,   0);
    #2 rst_n = 1'b1;
    y_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_valid", y_valid, 0);
      chk("post_rst_data",  y_data,  0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
